cue_aim_controller: RTL

Produces the cue aim vector and shot command for the billiard table. Player keys rotate the aim direction and charge shot power. The block drives the aim line's origin, vector and enable into the direction-line renderer, and issues a one-cycle shot command with launch velocity to the cue-ball physics. It sits between the keyboard decoder and the line renderer / ball physics, updating once per video frame so the drawn line never tears mid-frame.

---
 rtl/cue_aim_controller_pkg.sv | 37 +++
 rtl/cue_aim_controller_if.sv | 37 +++
 rtl/cue_aim_controller_aim_vector_lut.sv | 51 +++++
 rtl/cue_aim_controller.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cue_aim_controller_pkg.sv
// Shared types and constants for the cue aim controller: FSM states, quarter-sine table,
// power limits and the direction-times-power scaling helper.
package billiard_aim_pkg;

   localparam int unsigned ANGLE_W = 6;
   localparam int unsigned DIR_W   = 6;
   localparam int unsigned POWER_W = 4;
   localparam int unsigned COORD_W = 11;

   localparam logic [POWER_W-1:0] POWER_MIN = 4'd1;
   localparam logic [POWER_W-1:0] POWER_MAX = 4'd8;

   // Quarter-wave sine, amplitude 31, indexed 0..16 (0 to 90 degrees).
   localparam logic [4:0] SIN_LUT [17] = '{
      5'd0,  5'd3,  5'd6,  5'd9,  5'd12, 5'd15, 5'd17, 5'd20, 5'd22,
      5'd24, 5'd26, 5'd27, 5'd29, 5'd30, 5'd30, 5'd31, 5'd31
   };

   typedef enum logic [1:0] {
      AIM,
      CHARGE,
      WAIT_STOP
   } aim_state_t;

   // Signed direction component times unsigned power; result fits +/-248.
   function automatic logic signed [COORD_W-1:0] scale_dir(
      input logic signed [DIR_W-1:0] dir,
      input logic [POWER_W-1:0]      pwr
   );
      logic signed [COORD_W-1:0] dir_ext;
      logic signed [COORD_W-1:0] pwr_ext;
      dir_ext = {{(COORD_W - DIR_W){dir[DIR_W-1]}}, dir};
      pwr_ext = signed'({{(COORD_W - POWER_W){1'b0}}, pwr});
      return dir_ext * pwr_ext;
   endfunction

endpackage

// File: rtl/cue_aim_controller_if.sv
// Bundle of the per-frame key/ball inputs and the aim line / shot outputs of the controller.
interface cue_aim_controller_if;
   import billiard_aim_pkg::*;

   logic                      startOfFrame;
   logic                      leftKey;
   logic                      rightKey;
   logic                      shootKey;
   logic                      ballsMoving;
   logic signed [COORD_W-1:0] cueBallTopLeftX;
   logic signed [COORD_W-1:0] cueBallTopLeftY;

   logic signed [COORD_W-1:0] lineTopLeftPosX;
   logic signed [COORD_W-1:0] lineTopLeftPosY;
   logic signed [COORD_W-1:0] velocityX;
   logic signed [COORD_W-1:0] velocityY;
   logic                      lineEnable;
   logic                      shotValid;
   logic signed [COORD_W-1:0] shotVelocityX;
   logic signed [COORD_W-1:0] shotVelocityY;

   // Source side: keyboard decoder, ball physics status, and the consumers of the outputs.
   modport master (
      output startOfFrame, leftKey, rightKey, shootKey, ballsMoving,
      output cueBallTopLeftX, cueBallTopLeftY,
      input  lineTopLeftPosX, lineTopLeftPosY, velocityX, velocityY, lineEnable,
      input  shotValid, shotVelocityX, shotVelocityY
   );

   modport slave (
      input  startOfFrame, leftKey, rightKey, shootKey, ballsMoving,
      input  cueBallTopLeftX, cueBallTopLeftY,
      output lineTopLeftPosX, lineTopLeftPosY, velocityX, velocityY, lineEnable,
      output shotValid, shotVelocityX, shotVelocityY
   );

endinterface

// File: rtl/cue_aim_controller_aim_vector_lut.sv
// Combinational angle-to-direction lookup: 64 steps per turn, 0 = right, 16 = up (Y down).
module aim_vector_lut
   import billiard_aim_pkg::*;
(
   input  logic [ANGLE_W-1:0]      angle_i,
   output logic signed [DIR_W-1:0] dir_x_o,
   output logic signed [DIR_W-1:0] dir_y_o
);

   logic [1:0]              quad;
   logic [3:0]              step;
   logic [4:0]              idx_k;
   logic [4:0]              idx_c;
   logic signed [DIR_W-1:0] s_k;
   logic signed [DIR_W-1:0] s_c;

   assign quad  = angle_i[5:4];
   assign step  = angle_i[3:0];
   assign idx_k = {1'b0, step};
   assign idx_c = 5'd16 - idx_k;
   assign s_k   = signed'({1'b0, SIN_LUT[idx_k]});
   assign s_c   = signed'({1'b0, SIN_LUT[idx_c]});

   always_comb begin
      dir_x_o = '0;
      dir_y_o = '0;
      unique case (quad)
         2'd0: begin
            dir_x_o = s_c;
            dir_y_o = -s_k;
         end
         2'd1: begin
            dir_x_o = -s_k;
            dir_y_o = -s_c;
         end
         2'd2: begin
            dir_x_o = -s_c;
            dir_y_o = s_k;
         end
         2'd3: begin
            dir_x_o = s_k;
            dir_y_o = s_c;
         end
         default: begin
            dir_x_o = '0;
            dir_y_o = '0;
         end
      endcase
   end

endmodule

// File: rtl/cue_aim_controller.sv
// Cue aim FSM: rotates the aim angle, charges shot power, fires a one-cycle shot and waits for
// the table to settle. All decisions happen on startOfFrame; the line outputs follow one cycle later.
module cue_aim_controller
   import billiard_aim_pkg::*;
#(
   parameter int unsigned ROTATE_DIV = 4,
   parameter int unsigned CHARGE_DIV = 8,
   parameter int unsigned MIN_WAIT   = 30
) (
   input logic                 clk,
   input logic                 resetN,
   cue_aim_controller_if.slave aim_if
);

   localparam int unsigned CntMaxA = (ROTATE_DIV > CHARGE_DIV) ? ROTATE_DIV : CHARGE_DIV;
   localparam int unsigned CntMax  = (CntMaxA > MIN_WAIT) ? CntMaxA : MIN_WAIT;
   localparam int unsigned CntW    = $clog2(CntMax + 1);

   localparam logic [CntW-1:0] RotLast = CntW'(ROTATE_DIV - 1);
   localparam logic [CntW-1:0] ChgLast = CntW'(CHARGE_DIV - 1);
   localparam logic [CntW-1:0] WaitMax = CntW'(MIN_WAIT);

   aim_state_t                state_q;
   logic [ANGLE_W-1:0]        angle_q;
   logic [POWER_W-1:0]        power_q;
   logic [CntW-1:0]           frame_cnt_q;
   logic                      shoot_prev_q;
   logic                      sof_d1_q;
   logic signed [COORD_W-1:0] cue_x_q;
   logic signed [COORD_W-1:0] cue_y_q;
   logic                      shot_valid_q;
   logic signed [COORD_W-1:0] shot_vel_x_q;
   logic signed [COORD_W-1:0] shot_vel_y_q;

   logic signed [COORD_W-1:0] line_x_q;
   logic signed [COORD_W-1:0] line_y_q;
   logic signed [COORD_W-1:0] vel_x_q;
   logic signed [COORD_W-1:0] vel_y_q;
   logic                      line_en_q;

   logic signed [DIR_W-1:0]   dir_x;
   logic signed [DIR_W-1:0]   dir_y;
   logic signed [COORD_W-1:0] vel_x;
   logic signed [COORD_W-1:0] vel_y;
   logic                      shoot_rise;
   logic                      rotating;

   aim_vector_lut u_lut (
      .angle_i (angle_q),
      .dir_x_o (dir_x),
      .dir_y_o (dir_y)
   );

   assign vel_x      = scale_dir(dir_x, power_q);
   assign vel_y      = scale_dir(dir_y, power_q);
   assign shoot_rise = aim_if.shootKey && !shoot_prev_q;
   assign rotating   = aim_if.leftKey ^ aim_if.rightKey;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q      <= AIM;
         angle_q      <= '0;
         power_q      <= POWER_MIN;
         frame_cnt_q  <= '0;
         shoot_prev_q <= 1'b1;
         sof_d1_q     <= 1'b0;
         cue_x_q      <= '0;
         cue_y_q      <= '0;
         shot_valid_q <= 1'b0;
         shot_vel_x_q <= '0;
         shot_vel_y_q <= '0;
      end else begin
         shot_valid_q <= 1'b0;
         sof_d1_q     <= aim_if.startOfFrame;
         if (aim_if.startOfFrame) begin
            shoot_prev_q <= aim_if.shootKey;
            cue_x_q      <= aim_if.cueBallTopLeftX;
            cue_y_q      <= aim_if.cueBallTopLeftY;
            unique case (state_q)
               AIM: begin
                  if (shoot_rise) begin
                     state_q     <= CHARGE;
                     frame_cnt_q <= '0;
                  end else if (rotating) begin
                     if (frame_cnt_q == RotLast) begin
                        frame_cnt_q <= '0;
                        angle_q     <= aim_if.leftKey ? angle_q + 6'd1 : angle_q - 6'd1;
                     end else begin
                        frame_cnt_q <= frame_cnt_q + 1'b1;
                     end
                  end else begin
                     // Releasing (or pressing both) restarts the rotate delay.
                     frame_cnt_q <= '0;
                  end
               end
               CHARGE: begin
                  if (aim_if.shootKey) begin
                     if (frame_cnt_q == ChgLast) begin
                        frame_cnt_q <= '0;
                        if (power_q != POWER_MAX) begin
                           power_q <= power_q + 1'b1;
                        end
                     end else begin
                        frame_cnt_q <= frame_cnt_q + 1'b1;
                     end
                  end else begin
                     shot_valid_q <= 1'b1;
                     shot_vel_x_q <= vel_x >>> 2;
                     shot_vel_y_q <= vel_y >>> 2;
                     power_q      <= POWER_MIN;
                     frame_cnt_q  <= '0;
                     state_q      <= WAIT_STOP;
                  end
               end
               WAIT_STOP: begin
                  if (frame_cnt_q == WaitMax) begin
                     if (!aim_if.ballsMoving) begin
                        state_q     <= AIM;
                        frame_cnt_q <= '0;
                     end
                  end else begin
                     frame_cnt_q <= frame_cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_q     <= AIM;
                  frame_cnt_q <= '0;
               end
            endcase
         end
      end
   end

   // Line outputs load one cycle after SOF so they reflect the just-updated angle/power/state.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         line_x_q  <= '0;
         line_y_q  <= '0;
         vel_x_q   <= '0;
         vel_y_q   <= '0;
         line_en_q <= 1'b0;
      end else if (sof_d1_q) begin
         line_x_q  <= cue_x_q;
         line_y_q  <= cue_y_q;
         vel_x_q   <= vel_x;
         vel_y_q   <= vel_y;
         line_en_q <= (state_q != WAIT_STOP);
      end
   end

   assign aim_if.lineTopLeftPosX = line_x_q;
   assign aim_if.lineTopLeftPosY = line_y_q;
   assign aim_if.velocityX       = vel_x_q;
   assign aim_if.velocityY       = vel_y_q;
   assign aim_if.lineEnable      = line_en_q;
   assign aim_if.shotValid       = shot_valid_q;
   assign aim_if.shotVelocityX   = shot_vel_x_q;
   assign aim_if.shotVelocityY   = shot_vel_y_q;

   a_shot_single: assert property (@(posedge clk) disable iff (!resetN)
      shot_valid_q |=> !shot_valid_q);

   a_power_range: assert property (@(posedge clk) disable iff (!resetN)
      (power_q >= POWER_MIN) && (power_q <= POWER_MAX));

endmodule
